// File: rtl/data_memory_stage_pkg.sv
// Shared types and helpers for the MEM-stage data memory: access-size encodings,
// default depth, and the alignment / byte-enable / store-lane helpers.
package data_memory_stage_pkg;

  localparam int MEM_DEPTH_DEFAULT = 1024;

  typedef enum logic [1:0] {
    SIZE_WORD = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_BYTE = 2'b10,
    SIZE_RSVD = 2'b11
  } mem_size_e;

  // Reserved size behaves exactly like a word access.
  function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (mem_size_e'(size))
      SIZE_HALF: addr_misaligned = lane[0];
      SIZE_BYTE: addr_misaligned = 1'b0;
      default:   addr_misaligned = (lane != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lane);
    case (mem_size_e'(size))
      SIZE_HALF: byte_enables = lane[1] ? 4'b1100 : 4'b0011;
      SIZE_BYTE: byte_enables = 4'b0001 << lane;
      default:   byte_enables = 4'b1111;
    endcase
  endfunction

  // Right-justified store data copied into every lane; byte enables pick the live ones.
  function automatic logic [31:0] replicate_store(input logic [1:0] size, input logic [31:0] wdata);
    case (mem_size_e'(size))
      SIZE_HALF: replicate_store = {2{wdata[15:0]}};
      SIZE_BYTE: replicate_store = {4{wdata[7:0]}};
      default:   replicate_store = wdata;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_stage_if.sv
// Request/response bundle between the EX/MEM register (master) and the data memory stage (slave).
interface data_memory_stage_if;
  // MemRead/MemWrite are single-cycle request strobes qualified by the other request
  // fields in the same cycle; there is no ready: every request is accepted on the edge.
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  MemSize;
  logic        MemSigned;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MisalignedFault;
  logic        FaultSticky;
  logic [15:0] StoreCount;

  modport master (
    output MemRead, MemWrite, MemSize, MemSigned, Address, WriteData,
    input  ReadData, MisalignedFault, FaultSticky, StoreCount
  );

  modport slave (
    input  MemRead, MemWrite, MemSize, MemSigned, Address, WriteData,
    output ReadData, MisalignedFault, FaultSticky, StoreCount
  );
endinterface

// File: rtl/data_memory_stage_load_align_extend.sv
// Combinational lane select and sign/zero extension of a 32-bit memory word.
module load_align_extend
  import data_memory_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel = lane[1] ? word[31:16] : word[15:0];
    byte_sel = 8'(word >> {lane, 3'b000});
    case (mem_size_e'(size))
      SIZE_HALF: result = {{16{sign_ext & half_sel[15]}}, half_sel};
      SIZE_BYTE: result = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      default:   result = word;
    endcase
  end

endmodule

// File: rtl/data_memory_stage.sv
// MEM-stage data memory: combinational loads, one-entry store buffer with
// store-to-load forwarding, misalignment fault and committed-store counter.
module data_memory_stage
  import data_memory_stage_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT,
  parameter int IDX_W     = 10
) (
  input  logic                clk,
  input  logic                Reset,
  data_memory_stage_if.slave  bus,
  output logic                dbg_buf_valid
);

  logic [31:0] mem [MEM_DEPTH];

  logic             buf_valid;
  logic [IDX_W-1:0] buf_idx;
  logic [3:0]       buf_be;
  logic [31:0]      buf_data;
  logic             fault_sticky;
  logic [15:0]      store_count;

  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             misaligned;
  logic             store_ok;
  logic [31:0]      merged;
  logic [31:0]      extended;
  logic             unused_addr;

  assign idx         = bus.Address[IDX_W+1:2];
  assign lane        = bus.Address[1:0];
  assign unused_addr = ^bus.Address[31:IDX_W+2];
  assign misaligned  = addr_misaligned(bus.MemSize, lane);
  assign store_ok    = bus.MemWrite & ~misaligned;

  // Forward buffered bytes over the array word; untouched lanes come from the array.
  always_comb begin
    merged = mem[idx];
    for (int b = 0; b < 4; b++) begin
      if (buf_valid && buf_idx == idx && buf_be[b]) merged[8*b +: 8] = buf_data[8*b +: 8];
    end
  end

  load_align_extend u_align (
    .word     (merged),
    .lane     (lane),
    .size     (bus.MemSize),
    .sign_ext (bus.MemSigned),
    .result   (extended)
  );

  assign bus.ReadData        = (bus.MemRead && !bus.MemWrite && !misaligned) ? extended : 32'h0;
  assign bus.MisalignedFault = (bus.MemRead | bus.MemWrite) & misaligned;
  assign bus.FaultSticky     = fault_sticky;
  assign bus.StoreCount      = store_count;
  assign dbg_buf_valid       = buf_valid;

  // Array contents survive reset; only the buffered entry is lost.
  always_ff @(posedge clk) begin
    if (buf_valid) begin
      for (int b = 0; b < 4; b++) begin
        if (buf_be[b]) mem[buf_idx][8*b +: 8] <= buf_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      buf_valid    <= 1'b0;
      buf_idx      <= '0;
      buf_be       <= '0;
      buf_data     <= '0;
      fault_sticky <= 1'b0;
      store_count  <= '0;
    end else begin
      buf_valid <= store_ok;
      if (store_ok) begin
        buf_idx     <= idx;
        buf_be      <= byte_enables(bus.MemSize, lane);
        buf_data    <= replicate_store(bus.MemSize, bus.WriteData);
        store_count <= store_count + 16'd1;
      end
      if (bus.MisalignedFault) fault_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_memory_stage.sv
// Directed bench for data_memory_stage: hand-computed vectors, expected-value queue for loads.
module tb_data_memory_stage;
  import data_memory_stage_pkg::*;

  localparam int MEM_DEPTH = 1024;

  logic clk;
  logic Reset;
  logic dbg_buf_valid;
  int   n_cmp;
  int   n_fail;
  logic [31:0] exp_q[$];

  data_memory_stage_if bus ();

  data_memory_stage #(.MEM_DEPTH(MEM_DEPTH), .IDX_W(10)) dut (
    .clk           (clk),
    .Reset         (Reset),
    .bus           (bus),
    .dbg_buf_valid (dbg_buf_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL timeout: got no-finish expected finish");
    $fatal(1, "simulation time limit");
  end

  // checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_read(input string tag);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    check(tag, bus.ReadData, exp);
  endtask

  // drivers: inputs change 1 time unit after the rising edge, then settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
    bus.MemRead   = rd;
    bus.MemWrite  = wr;
    bus.MemSize   = size;
    bus.MemSigned = sgn;
    bus.Address   = addr;
    bus.WriteData = wdata;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic load(input logic [1:0] size, input logic sgn, input logic [31:0] addr);
    drive(1'b1, 1'b0, size, sgn, addr, 32'h0);
  endtask

  task automatic store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    drive(1'b0, 1'b1, size, 1'b0, addr, wdata);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    Reset  = 1'b1;
    idle();
    step();
    step();
    check("rst_sticky", 32'(bus.FaultSticky), 32'h0);
    check("rst_count", 32'(bus.StoreCount), 32'h0);
    check("rst_bufvalid", 32'(dbg_buf_valid), 32'h0);
    check("rst_rdata", bus.ReadData, 32'h0);
    Reset = 1'b0;

    // word store then forwarded load, then array load
    store(SIZE_WORD, 32'h10, 32'hDEADBEEF);
    check("st_nofault", 32'(bus.MisalignedFault), 32'h0);
    step();
    load(SIZE_WORD, 1'b0, 32'h10);
    exp_q.push_back(32'hDEADBEEF);
    check_read("fwd_word");
    check("count_1", 32'(bus.StoreCount), 32'd1);
    check("buf_valid_1", 32'(dbg_buf_valid), 32'h1);
    step();
    idle();
    check("rd_idle_zero", bus.ReadData, 32'h0);
    step();
    step();
    load(SIZE_WORD, 1'b0, 32'h10);
    exp_q.push_back(32'hDEADBEEF);
    check_read("array_word");

    // sub-word extension
    store(SIZE_WORD, 32'h20, 32'h80FF7F01);
    step();
    idle();
    step();
    load(SIZE_BYTE, 1'b1, 32'h23);
    exp_q.push_back(32'hFFFFFF80);
    check_read("byte_s_23");
    load(SIZE_BYTE, 1'b0, 32'h22);
    exp_q.push_back(32'h000000FF);
    check_read("byte_u_22");
    load(SIZE_HALF, 1'b1, 32'h20);
    exp_q.push_back(32'h00007F01);
    check_read("half_s_20");
    load(SIZE_HALF, 1'b1, 32'h22);
    exp_q.push_back(32'hFFFF80FF);
    check_read("half_s_22");
    load(SIZE_WORD, 1'b1, 32'h20);
    exp_q.push_back(32'h80FF7F01);
    check_read("word_ignores_sign");

    // partial merge: byte store forwarded over a just-committed word
    store(SIZE_WORD, 32'h40, 32'h11223344);
    step();
    store(SIZE_BYTE, 32'h41, 32'h000000AA);
    step();
    load(SIZE_WORD, 1'b0, 32'h40);
    exp_q.push_back(32'h1122AA44);
    check_read("merge_word");
    check("count_4", 32'(bus.StoreCount), 32'd4);
    step();

    // misaligned store is dropped, misaligned load reads zero
    store(SIZE_WORD, 32'h42, 32'hFFFFFFFF);
    check("mis_fault", 32'(bus.MisalignedFault), 32'h1);
    check("mis_sticky_pre", 32'(bus.FaultSticky), 32'h0);
    step();
    idle();
    check("mis_sticky", 32'(bus.FaultSticky), 32'h1);
    check("mis_count", 32'(bus.StoreCount), 32'd4);
    check("mis_nobuf", 32'(dbg_buf_valid), 32'h0);
    load(SIZE_WORD, 1'b0, 32'h40);
    exp_q.push_back(32'h1122AA44);
    check_read("mis_mem_kept");
    load(SIZE_HALF, 1'b1, 32'h43);
    exp_q.push_back(32'h0);
    check_read("mis_half_load");
    check("mis_load_fault", 32'(bus.MisalignedFault), 32'h1);
    step();

    // reset with a store pending in the buffer
    store(SIZE_WORD, 32'h80, 32'h12345678);
    step();
    check("pend_valid", 32'(dbg_buf_valid), 32'h1);
    idle();
    Reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(dbg_buf_valid), 32'h0);
    check("mid_rst_sticky", 32'(bus.FaultSticky), 32'h0);
    check("mid_rst_count", 32'(bus.StoreCount), 32'h0);
    load(SIZE_WORD, 1'b0, 32'h80);
    exp_q.push_back(32'h0);
    check_read("mid_rst_load");
    step();
    Reset = 1'b0;
    step();
    load(SIZE_WORD, 1'b0, 32'h80);
    exp_q.push_back(32'h0);
    check_read("rst_discarded");

    // address wrap and read/write conflict
    store(SIZE_WORD, 32'(MEM_DEPTH * 4 + 4), 32'h5A5A5A5A);
    step();
    load(SIZE_WORD, 1'b0, 32'h4);
    exp_q.push_back(32'h5A5A5A5A);
    check_read("wrap_fwd");
    drive(1'b1, 1'b1, SIZE_WORD, 1'b0, 32'h8, 32'hCAFEF00D);
    exp_q.push_back(32'h0);
    check_read("conflict_rdata");
    step();
    load(SIZE_WORD, 1'b0, 32'h8);
    exp_q.push_back(32'hCAFEF00D);
    check_read("conflict_fwd");
    step();
    step();
    load(SIZE_WORD, 1'b0, 32'h8);
    exp_q.push_back(32'hCAFEF00D);
    check_read("conflict_array");
    load(SIZE_WORD, 1'b0, 32'h4);
    exp_q.push_back(32'h5A5A5A5A);
    check_read("wrap_array");
    check("count_2", 32'(bus.StoreCount), 32'd2);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_stage.md
Name: data_memory_stage

Overview:
- MEM-stage data memory for the pipelined SAD datapath. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Performs word, halfword and byte loads and stores.
- Stores pass through a one-entry write buffer with store-to-load forwarding. ReadData is combinational so MEM/WB can capture it in the same cycle.
- Flags misaligned accesses with a combinational fault and a sticky fault bit.

Parameters:
- MEM_DEPTH, 1024, number of 32-bit words; power of two.
- IDX_W, 10, log2(MEM_DEPTH); word-index width.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-high reset.
- MemRead  in  1  load request this cycle.
- MemWrite  in  1  store request this cycle.
- MemSize  in  2  access size: 00 word, 01 half, 10 byte, 11 reserved (treated as word).
- MemSigned  in  1  1 = sign-extend sub-word loads, 0 = zero-extend.
- Address  in  32  byte address from the ALU result.
- WriteData  in  32  store data, right-justified for sub-word stores.
- ReadData  out  32  load result, combinational.
- MisalignedFault  out  1  combinational; current access is misaligned.
- FaultSticky  out  1  registered; set on any misaligned access, cleared only by Reset.
- StoreCount  out  16  registered count of committed-accepted stores; wraps at 0xFFFF to 0.

Behaviour:
- Addressing:
  - Word index = Address[IDX_W+1:2]; upper address bits are ignored, so addresses wrap modulo MEM_DEPTH*4.
  - Byte lanes are little-endian: lane k = bits 8k+7:8k, and lane = Address[1:0].
- Alignment:
  - Half requires Address[0]=0. Word and reserved sizes require Address[1:0]=00.
  - MisalignedFault = (MemRead|MemWrite) & misaligned.
  - A misaligned store is dropped: no buffer capture, no count.
  - A misaligned load returns ReadData=0.
- Write buffer:
  - State: buf_valid, buf_idx[IDX_W], buf_be[4], buf_data[32].
  - On each posedge, in order: (1) if buf_valid, write buf_data lanes selected by buf_be into mem[buf_idx]; (2) if MemWrite and aligned, capture the new store with buf_valid=1, otherwise set buf_valid=0.
  - Back-to-back stores therefore commit the old entry and capture the new one on the same edge.
  - Byte enables: byte = 1<<lane; half = 0011 or 1100 by Address[1]; word = 1111.
  - WriteData is replicated into the selected lanes.
- Load path (combinational):
  - raw = mem[idx]. If buf_valid and buf_idx==idx, each byte with buf_be set is taken from buf_data.
  - The result is then lane-extracted by Address[1:0] and sign- or zero-extended per MemSigned. Word loads ignore MemSigned.
- Read/write conflicts:
  - MemRead=1 and MemWrite=1 is illegal: the store proceeds and ReadData=0.
  - MemRead=0 gives ReadData=0.
- Memory contents:
  - All words are zero at time zero and are unaffected by Reset.
- Reset (asynchronous):
  - buf_valid=0, FaultSticky=0, StoreCount=0.
  - A pending buffered store is discarded, including on reset mid-operation.
  - ReadData follows inputs immediately, using the unmerged memory word.
- StoreCount increments on each posedge where an aligned store is captured.
- Latency:
  - Loads: 0 cycles (combinational).
  - Stores are visible to loads from the next cycle via forwarding, and in the array from 2 edges after issue.

Decomposition:
- Shared package holds:
  - MemSize encodings: SIZE_WORD=2'b00, SIZE_HALF=2'b01, SIZE_BYTE=2'b10.
  - MEM_DEPTH default.
- One sub-module, load_align_extend: combinational lane select plus sign/zero extension (inputs word, lane, size, signed). It is reused by a future forwarding unit.

Test Plan:
- Word store then load: store 0xDEADBEEF @0x10, load @0x10 on the next cycle -> ReadData=0xDEADBEEF via forwarding; load again 3 cycles later -> same value from the array.
- Sub-word sign/zero extension: word 0x80FF7F01 @0x20; byte signed @0x23 -> 0xFFFFFF80; byte unsigned @0x22 -> 0x000000FF; half signed @0x20 -> 0x00007F01; half signed @0x22 -> 0xFFFF80FF.
- Partial merge: word 0x11223344 @0x40, then byte store 0xAA @0x41 immediately followed by a word load @0x40 -> 0x1122AA44; StoreCount=2.
- Misaligned: word store @0x42 -> MisalignedFault=1 that cycle, FaultSticky=1 after the edge, memory @0x40 unchanged, StoreCount unchanged; half load @0x43 -> ReadData=0.
- Reset mid-operation: store 0x12345678 @0x80, assert Reset before the next edge -> buf_valid=0, FaultSticky=0, StoreCount=0, load @0x80 returns 0x00000000.
- Wrap and conflict: store 0x5A5A5A5A @(MEM_DEPTH*4+0x4) -> load @0x4 returns 0x5A5A5A5A; MemRead=MemWrite=1 -> ReadData=0 and the store is committed.
